// File: rtl/basys3_pkg.sv
// basys3_pkg: constants shared by the Basys3 button/LED glue logic.
//   THERMO_WIDTH        - length of the thermometer code on the LED bank
//   THERMO_COUNT_WIDTH  - bits needed to hold a level 0..THERMO_WIDTH
//   *_100MHZ            - default debounce / auto-repeat timings for the
//                         100 MHz board clock
//   ctr_bits()          - width of a counter that must reach n-1
package basys3_pkg;

  localparam int THERMO_WIDTH          = 16;
  localparam int THERMO_COUNT_WIDTH    = $clog2(THERMO_WIDTH + 1);

  localparam int DEBOUNCE_CYCLES_100MHZ = 1000000;   // 10 ms
  localparam int REPEAT_DELAY_100MHZ    = 50000000;  // 500 ms
  localparam int REPEAT_PERIOD_100MHZ   = 10000000;  // 100 ms

  // Counters here compare against n-1 and then wrap to zero, so they only
  // ever hold 0..n-1. Never return zero width.
  function automatic int ctr_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: conditions one raw push-button into step requests.
//   clk    - board clock, rising edge
//   reset  - synchronous, active-high; button is treated as released
//   btn    - raw asynchronous button level
//   step   - one-cycle pulse: on the debounced press, at REPEAT_DELAY
//            cycles after it, then every REPEAT_PERIOD cycles while held
module btn_debounce
  import basys3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_100MHZ,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MHZ
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic step
);

  localparam int DB_W   = ctr_bits(DEBOUNCE_CYCLES);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = ctr_bits(RP_MAX);

  logic            sync_meta;
  logic            sync_out;
  logic            level;
  logic [DB_W-1:0] stable_cnt;
  logic [RP_W-1:0] rep_cnt;
  logic            repeating;   // first repeat already issued for this press

  logic            flip;
  logic [RP_W-1:0] rep_limit;
  logic            rep_fire;

  // The synchronized input has disagreed with the accepted level for
  // DEBOUNCE_CYCLES consecutive cycles as of this edge.
  assign flip = (sync_out != level) &&
                (stable_cnt == DB_W'(DEBOUNCE_CYCLES - 1));

  // rep_cnt holds (cycles since last step - 1); the first interval after the
  // press edge is REPEAT_DELAY, later ones REPEAT_PERIOD.
  assign rep_limit = repeating ? RP_W'(REPEAT_PERIOD - 1) : RP_W'(REPEAT_DELAY - 1);

  // No repeat on the edge where the debounced level is dropping: a release
  // cancels any step that would otherwise coincide with it.
  assign rep_fire = level && !flip && (rep_cnt == rep_limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta  <= 1'b0;
      sync_out   <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
      rep_cnt    <= '0;
      repeating  <= 1'b0;
      step       <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync_out  <= sync_meta;

      // Any cycle agreeing with the accepted level (a bounce) restarts the run.
      if (sync_out == level || flip) begin
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + DB_W'(1);
      end

      if (flip) begin
        level <= sync_out;
      end

      step <= (flip && sync_out) || rep_fire;

      if (!level || flip) begin
        rep_cnt   <= '0;
        repeating <= 1'b0;
      end else if (rep_fire) begin
        rep_cnt   <= '0;
        repeating <= 1'b1;
      end else begin
        rep_cnt   <= rep_cnt + RP_W'(1);
      end
    end
  end

endmodule

// File: rtl/thermo_count_gen.sv
// thermo_count_gen: button-driven saturating level 0..WIDTH shown as a
// thermometer code on the LED bank.
//   clk      - 100 MHz board clock, rising edge
//   reset    - synchronous, active-high
//   btnU     - raw increment button
//   btnD     - raw decrement button
//   led      - thermometer code, led[i] = (i < count)
//   count    - current level 0..WIDTH
//   changed  - one-cycle pulse in the cycle count takes a new value
module thermo_count_gen
  import basys3_pkg::*;
#(
  parameter int WIDTH           = THERMO_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_100MHZ,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MHZ
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       btnU,
  input  logic                       btnD,
  output logic [WIDTH-1:0]           led,
  output logic [$clog2(WIDTH+1)-1:0] count,
  output logic                       changed
);

  localparam int CW = $clog2(WIDTH + 1);

  logic          inc_step;
  logic          dec_step;
  logic [CW-1:0] count_next;
  logic [WIDTH-1:0] led_next;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_btn_up (
    .clk   (clk),
    .reset (reset),
    .btn   (btnU),
    .step  (inc_step)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_btn_dn (
    .clk   (clk),
    .reset (reset),
    .btn   (btnD),
    .step  (dec_step)
  );

  // Saturation is tested before the add/subtract so the count never wraps;
  // simultaneous requests cancel.
  always_comb begin
    count_next = count;
    if (inc_step && !dec_step && count != CW'(WIDTH)) begin
      count_next = count + CW'(1);
    end else if (dec_step && !inc_step && count != '0) begin
      count_next = count - CW'(1);
    end
  end

  // Decoding from count_next keeps the led register in step with count.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_thermo
    assign led_next[gi] = (count_next > CW'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      led     <= '0;
      changed <= 1'b0;
    end else begin
      count   <= count_next;
      led     <= led_next;
      changed <= (count_next != count);
    end
  end

endmodule
